dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Shares the single data-memory (DRAM) port between core 1, core 2 and the external load/readback path of the dual-core top.
- Cores issue single-word read/write requests through a req/ack handshake.
- The external path has priority while ext_mode is high (DRAM load before run, readback after run).
- Core arbitration is round-robin. One access is outstanding at a time; the DRAM has a 1-cycle synchronous read.

Parameters:
- ADDR_W, 9, DRAM word address width
- DATA_W, 16, DRAM word width

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  synchronous active-low reset
- ext_mode  in  1  1 = external path owns DRAM; core requests stall
- ext_req  in  1  external access request; rising edge starts exactly one access
- ext_we  in  1  1 = write, 0 = read (sampled with the ext_req rising edge)
- ext_addr  in  ADDR_W  external address
- ext_wdata  in  DATA_W  external write data
- ext_rdata  out  DATA_W  external read data; held until the next external read
- ext_done  out  1  one-cycle pulse when the external access completes
- c1_req, c2_req  in  1  core request; must be held until the matching ack
- c1_we, c2_we  in  1  core write enable
- c1_addr, c2_addr  in  ADDR_W  core address
- c1_wdata, c2_wdata  in  DATA_W  core write data
- c1_ack, c2_ack  out  1  one-cycle completion pulse
- c_rdata  out  DATA_W  read data, valid in the ack cycle
- mem_en  out  1  DRAM enable (registered)
- mem_we  out  1  DRAM write enable (registered)
- mem_addr  out  ADDR_W  DRAM address (registered)
- mem_wdata  out  DATA_W  DRAM write data (registered)
- mem_rdata  in  DATA_W  DRAM read data, valid the cycle after mem_en with mem_we=0
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE; all mem_* = 0; all acks/done = 0; ext_rdata = 0; c_rdata = 0.
  - last_grant = core 2, so core 1 wins the first tie.
  - ext_req edge register = 0.
  - Reset mid-access aborts the access with no ack. A write already driven to the DRAM is not undone.
- FSM states: IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE, sampling inputs at edge N:
  - if ext_mode=1 and an ext_req rising edge is detected (ext_req=1, prev=0): latch the external request, owner=EXT.
  - else if ext_mode=0: pick a core by round-robin.
    - If only one of c1_req/c2_req is high, grant it.
    - If both are high, grant the core that is not last_grant.
    - Update last_grant to the granted core.
  - On any grant: mem_en=1, mem_we, mem_addr and mem_wdata are registered from the owner's inputs; go to ISSUE.
  - With no grant: stay in IDLE with mem_en=0.
- ISSUE (edge N+1): mem_en and mem_we return to 0; go to WAIT. The DRAM performs the access at this edge.
- WAIT (edge N+2):
  - Capture mem_rdata if the access was a read.
  - Pulse the owner's ack/done for one cycle.
  - Core read data goes on c_rdata; external read data goes on ext_rdata.
  - Go to IDLE.
- Latency: request sampled to ack = 2 cycles. Throughput: 1 access per 3 cycles. A core holding req continuously is re-granted from the IDLE edge after its ack.
- Write ack means the DRAM has been written. Reading the same address back afterwards returns the new data.
- ext_mode rules:
  - ext_mode=1 blocks core grants only at IDLE. An in-flight core access completes normally (no preemption).
  - ext_mode falling while an external access is in flight: that access still completes.
  - ext_req held high for many cycles produces exactly one access.
  - A rising edge seen while busy is not lost: it is latched as pending and serviced at the next IDLE.
- Core req dropped before ack: this is a protocol violation and the access still completes. Bench asserts on it.
- last_grant updates only on core grants; external accesses do not change it.
- Width: addresses and data pass through unmodified. No arithmetic other than the 1-bit edge detect and pointer.

Decomposition:
- Shared package `proc_pkg`: ADDR_W/DATA_W defaults, FSM state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2), owner encoding (NONE, C1, C2, EXT).
- One sub-module, `rr_arb2`: 2-way round-robin picker holding last_grant. Inputs req[1:0] and advance; outputs a one-hot grant.
- The FSM and the external edge detect stay in the top module.

Test Plan:
- External load: ext_mode=1; four ext_req pulses, each held 4 cycles, writing addr 1..4 with data 10,20,30,40 -> exactly 4 mem_en pulses and 4 ext_done pulses. External reads of addr 1..4 then return 10,20,30,40 on ext_rdata.
- Single core read: ext_mode=0; c1_req with addr 3 held -> c1_ack 2 cycles after the sampling edge, c_rdata=30. c2_ack never pulses.
- Contention: c1_req and c2_req both held continuously for 6 accesses, out of reset -> grant order C1,C2,C1,C2,C1,C2. Each ack is spaced 3 cycles apart.
- Write/read coherence: c2 writes 0xBEEF to addr 7, then c1 reads addr 7 -> c_rdata=0xBEEF.
- Mode switch mid-access: c1 read in ISSUE when ext_mode rises with an ext_req edge -> c1_ack completes first. The external access follows 1 cycle after return to IDLE. c2_req stays stalled until ext_mode=0.
- Reset mid-access: reset_n=0 during WAIT -> no ack; all outputs 0 next cycle. After release, c1 wins the first tie.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the DRAM arbiter: default widths, FSM state and
// access-owner encodings.
package proc_pkg;

   localparam int PROC_ADDR_W = 9;
   localparam int PROC_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      C1   = 2'd1,
      C2   = 2'd2,
      EXT  = 2'd3
   } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. grant is combinational from req; the
// last-granted pointer moves only when the caller accepts the grant.
module rr_arb2 (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic last_c2;

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = last_c2 ? 2'b01 : 2'b10;
      end
   end

   // Reset to "core 2 went last" so core 1 wins the first tie.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         last_c2 <= 1'b1;
      end else if (advance && (grant != 2'b00)) begin
         last_c2 <= grant[1];
      end
   end

endmodule

// File: rtl/dram_arbiter.sv
// Shares one synchronous-read DRAM port between two cores and the external
// load/readback path; one access in flight, IDLE -> ISSUE -> WAIT -> IDLE.
module dram_arbiter
   import proc_pkg::*;
#(
   parameter int ADDR_W = PROC_ADDR_W,
   parameter int DATA_W = PROC_DATA_W
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              ext_mode,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              ext_done,
   input  logic              c1_req,
   input  logic              c1_we,
   input  logic [ADDR_W-1:0] c1_addr,
   input  logic [DATA_W-1:0] c1_wdata,
   output logic              c1_ack,
   input  logic              c2_req,
   input  logic              c2_we,
   input  logic [ADDR_W-1:0] c2_addr,
   input  logic [DATA_W-1:0] c2_wdata,
   output logic              c2_ack,
   output logic [DATA_W-1:0] c_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output state_t            dbg_state
);

   // Handshake: a core raises cN_req with we/addr/wdata stable and holds them
   // until cN_ack pulses for one cycle (read data on c_rdata in that cycle);
   // the external path instead starts one access per ext_req rising edge.

   state_t              state;
   owner_t              owner;
   logic                op_rd;
   logic                ext_prev;
   logic                ext_pend;
   logic                ext_edge;
   logic                x_we;
   logic [ADDR_W-1:0]   x_addr;
   logic [DATA_W-1:0]   x_wdata;
   logic [1:0]          core_req;
   logic [1:0]          core_gnt;
   logic                ext_go;
   logic                core_go;
   owner_t              sel_owner;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   assign ext_edge  = ext_req & ~ext_prev;
   assign core_req  = {c2_req, c1_req};
   assign ext_go    = (state == IDLE) && ext_mode && (ext_edge || ext_pend);
   assign core_go   = (state == IDLE) && !ext_mode && (core_req != 2'b00);
   assign busy      = (state != IDLE);
   assign dbg_state = state;

   rr_arb2 u_rr (
      .clock   (clock),
      .reset_n (reset_n),
      .req     (core_req),
      .advance (core_go),
      .grant   (core_gnt)
   );

   // A fresh edge carries live inputs; a pending one replays what was latched.
   always_comb begin
      sel_owner = NONE;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      if (ext_go) begin
         sel_owner = EXT;
         sel_we    = ext_edge ? ext_we    : x_we;
         sel_addr  = ext_edge ? ext_addr  : x_addr;
         sel_wdata = ext_edge ? ext_wdata : x_wdata;
      end else if (core_go && core_gnt[0]) begin
         sel_owner = C1;
         sel_we    = c1_we;
         sel_addr  = c1_addr;
         sel_wdata = c1_wdata;
      end else if (core_go && core_gnt[1]) begin
         sel_owner = C2;
         sel_we    = c2_we;
         sel_addr  = c2_addr;
         sel_wdata = c2_wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= IDLE;
         owner     <= NONE;
         op_rd     <= 1'b0;
         ext_prev  <= 1'b0;
         ext_pend  <= 1'b0;
         x_we      <= 1'b0;
         x_addr    <= '0;
         x_wdata   <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         c1_ack    <= 1'b0;
         c2_ack    <= 1'b0;
         ext_done  <= 1'b0;
         ext_rdata <= '0;
         c_rdata   <= '0;
      end else begin
         c1_ack   <= 1'b0;
         c2_ack   <= 1'b0;
         ext_done <= 1'b0;
         ext_prev <= ext_req;
         if (ext_edge) begin
            x_we    <= ext_we;
            x_addr  <= ext_addr;
            x_wdata <= ext_wdata;
         end
         if (ext_edge && (state != IDLE)) begin
            ext_pend <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (sel_owner != NONE) begin
                  owner     <= sel_owner;
                  op_rd     <= ~sel_we;
                  mem_en    <= 1'b1;
                  mem_we    <= sel_we;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  state     <= ISSUE;
                  if (sel_owner == EXT) begin
                     ext_pend <= 1'b0;
                  end
               end else begin
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
               end
            end
            ISSUE: begin
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               state  <= WAIT;
            end
            WAIT: begin
               case (owner)
                  C1: begin
                     c1_ack <= 1'b1;
                     if (op_rd) c_rdata <= mem_rdata;
                  end
                  C2: begin
                     c2_ack <= 1'b1;
                     if (op_rd) c_rdata <= mem_rdata;
                  end
                  EXT: begin
                     ext_done <= 1'b1;
                     if (op_rd) ext_rdata <= mem_rdata;
                  end
                  default: ;
               endcase
               owner <= NONE;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: behavioural DRAM, shadow memory for
// expected data, scoreboard queues for read data and grant order.
module tb_dram_arbiter;
   import proc_pkg::*;

   localparam int AW = 9;
   localparam int DW = 16;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          ext_mode = 1'b0;
   logic          ext_req = 1'b0;
   logic          ext_we = 1'b0;
   logic [AW-1:0] ext_addr = '0;
   logic [DW-1:0] ext_wdata = '0;
   logic [DW-1:0] ext_rdata;
   logic          ext_done;
   logic          c1_req = 1'b0, c1_we = 1'b0;
   logic [AW-1:0] c1_addr = '0;
   logic [DW-1:0] c1_wdata = '0;
   logic          c1_ack;
   logic          c2_req = 1'b0, c2_we = 1'b0;
   logic [AW-1:0] c2_addr = '0;
   logic [DW-1:0] c2_wdata = '0;
   logic          c2_ack;
   logic [DW-1:0] c_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          busy;
   state_t        dbg_state;

   logic [DW-1:0] dram [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   logic [DW-1:0] exp_q[$];
   int            gnt_q[$];

   int n_tests = 0;
   int n_fail = 0;
   int mem_en_cnt = 0, done_cnt = 0, c1_cnt = 0, c2_cnt = 0;
   bit c1_owed = 1'b0, c2_owed = 1'b0;

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   dram_arbiter dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .ext_mode  (ext_mode),
      .ext_req   (ext_req),
      .ext_we    (ext_we),
      .ext_addr  (ext_addr),
      .ext_wdata (ext_wdata),
      .ext_rdata (ext_rdata),
      .ext_done  (ext_done),
      .c1_req    (c1_req),
      .c1_we     (c1_we),
      .c1_addr   (c1_addr),
      .c1_wdata  (c1_wdata),
      .c1_ack    (c1_ack),
      .c2_req    (c2_req),
      .c2_we     (c2_we),
      .c2_addr   (c2_addr),
      .c2_wdata  (c2_wdata),
      .c2_ack    (c2_ack),
      .c_rdata   (c_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // One-cycle synchronous-read DRAM.
   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_we) dram[mem_addr] <= mem_wdata;
         else        mem_rdata <= dram[mem_addr];
      end
   end

   // Pulse counters and core-side request protocol monitor.
   always @(negedge clock) begin
      if (mem_en)   mem_en_cnt++;
      if (ext_done) done_cnt++;
      if (c1_ack)   c1_cnt++;
      if (c2_ack)   c2_cnt++;
      if ((c1_owed && !c1_req) || (c2_owed && !c2_req)) begin
         n_fail++;
         $error("FAIL protocol: req dropped before ack c1=%0d c2=%0d", c1_req, c2_req);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_tests++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic wait_ack(input int core, output int n, output bit got);
      n = 0;
      got = 1'b0;
      while (!got && n < 30) begin
         @(negedge clock);
         n++;
         if ((core == 1) ? c1_ack : c2_ack) got = 1'b1;
      end
   endtask

   task automatic ext_op(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input string tag);
      int n;
      bit got;
      n = 0;
      got = 1'b0;
      ext_we = we;
      ext_addr = addr;
      ext_wdata = wd;
      ext_req = 1'b1;
      if (we) ref_mem[addr] = wd;
      else    exp_q.push_back(ref_mem[addr]);
      for (int i = 1; i <= 30; i++) begin
         @(negedge clock);
         if (i == 4) ext_req = 1'b0;
         if (ext_done && !got) begin
            got = 1'b1;
            n = i;
         end
         if (got && i >= 4) break;
      end
      ext_req = 1'b0;
      check({tag, "_done"}, 32'(got), 1);
      check({tag, "_lat"}, n, 3);
      if (!we) check({tag, "_data"}, 32'(ext_rdata), 32'(exp_q.pop_front()));
      @(negedge clock);
   endtask

   task automatic core_op(input int core, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input string tag);
      int n;
      bit got;
      if (core == 1) begin
         c1_we = we; c1_addr = addr; c1_wdata = wd; c1_req = 1'b1; c1_owed = 1'b1;
      end else begin
         c2_we = we; c2_addr = addr; c2_wdata = wd; c2_req = 1'b1; c2_owed = 1'b1;
      end
      if (we) ref_mem[addr] = wd;
      else    exp_q.push_back(ref_mem[addr]);
      wait_ack(core, n, got);
      if (core == 1) begin
         c1_owed = 1'b0; c1_req = 1'b0;
      end else begin
         c2_owed = 1'b0; c2_req = 1'b0;
      end
      check({tag, "_ack"}, 32'(got), 1);
      check({tag, "_lat"}, n, 3);
      if (!we) check({tag, "_data"}, 32'(c_rdata), 32'(exp_q.pop_front()));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int en0, d0, k1, k2, seen, last, id, n;
      bit got;
      foreach (ref_mem[i]) ref_mem[i] = '0;

      do_reset();
      check("rst_mem", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 0);
      check("rst_acks", 32'({c1_ack, c2_ack, ext_done}), 0);
      check("rst_ext_rdata", 32'(ext_rdata), 0);
      check("rst_c_rdata", 32'(c_rdata), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));

      // External load then readback, one access per held ext_req.
      ext_mode = 1'b1;
      en0 = mem_en_cnt;
      d0 = done_cnt;
      for (int i = 1; i <= 4; i++) ext_op(1'b1, AW'(i), DW'(i * 10), "ext_wr");
      check("ext_load_mem_en", mem_en_cnt - en0, 4);
      check("ext_load_done", done_cnt - d0, 4);
      for (int i = 1; i <= 4; i++) ext_op(1'b0, AW'(i), '0, "ext_rd");
      ext_mode = 1'b0;

      // Single core read.
      k2 = c2_cnt;
      core_op(1, 1'b0, 9'd3, '0, "c1_rd3");
      check("c1_rd3_no_c2", c2_cnt - k2, 0);

      // Contention out of reset: strict alternation starting with core 1.
      do_reset();
      c1_we = 1'b0; c1_addr = 9'd1;
      c2_we = 1'b0; c2_addr = 9'd2;
      for (int k = 0; k < 6; k++) begin
         gnt_q.push_back((k % 2 == 0) ? 1 : 2);
         exp_q.push_back((k % 2 == 0) ? ref_mem[1] : ref_mem[2]);
      end
      c1_req = 1'b1; c1_owed = 1'b1;
      c2_req = 1'b1; c2_owed = 1'b1;
      seen = 0;
      last = 0;
      for (int cyc = 1; cyc <= 40 && seen < 6; cyc++) begin
         @(negedge clock);
         if (c1_ack || c2_ack) begin
            id = c1_ack ? 1 : 2;
            check("rr_order", id, gnt_q.pop_front());
            check("rr_data", 32'(c_rdata), 32'(exp_q.pop_front()));
            check("rr_spacing", cyc - last, 3);
            last = cyc;
            seen++;
         end
      end
      c1_owed = 1'b0; c1_req = 1'b0;
      c2_owed = 1'b0; c2_req = 1'b0;
      check("rr_count", seen, 6);
      gnt_q.delete();
      exp_q.delete();

      // Write/read coherence across cores.
      core_op(2, 1'b1, 9'd7, 16'hBEEF, "c2_wr7");
      core_op(1, 1'b0, 9'd7, '0, "c1_rd7");

      // Mode switch while a core read is in ISSUE.
      en0 = mem_en_cnt;
      k2 = c2_cnt;
      c1_we = 1'b0; c1_addr = 9'd4; c1_req = 1'b1; c1_owed = 1'b1;
      exp_q.push_back(ref_mem[4]);
      @(negedge clock);
      check("ms_state_issue", 32'(dbg_state), 32'(ISSUE));
      ext_mode = 1'b1; ext_we = 1'b0; ext_addr = 9'd2; ext_req = 1'b1;
      exp_q.push_back(ref_mem[2]);
      c2_we = 1'b1; c2_addr = 9'd5; c2_wdata = 16'h1234; c2_req = 1'b1; c2_owed = 1'b1;
      ref_mem[5] = 16'h1234;
      repeat (2) @(negedge clock);
      check("ms_c1_ack", 32'(c1_ack), 1);
      check("ms_c1_rdata", 32'(c_rdata), 32'(exp_q.pop_front()));
      check("ms_no_ext_yet", 32'(ext_done), 0);
      c1_owed = 1'b0; c1_req = 1'b0;
      @(negedge clock);
      check("ms_ext_issue", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 9'd2}));
      repeat (2) @(negedge clock);
      check("ms_ext_done", 32'(ext_done), 1);
      check("ms_ext_rdata", 32'(ext_rdata), 32'(exp_q.pop_front()));
      repeat (6) @(negedge clock);
      check("ms_c2_stalled", c2_cnt - k2, 0);
      check("ms_one_ext", mem_en_cnt - en0, 2);
      ext_req = 1'b0;
      ext_mode = 1'b0;
      wait_ack(2, n, got);
      c2_owed = 1'b0; c2_req = 1'b0;
      check("ms_c2_ack", 32'(got), 1);
      check("ms_c2_lat", n, 3);

      // Reset during WAIT aborts the access; core 1 then wins the tie.
      c1_we = 1'b0; c1_addr = 9'd1; c1_req = 1'b1; c1_owed = 1'b1;
      repeat (2) @(negedge clock);
      check("rm_state_wait", 32'(dbg_state), 32'(WAIT));
      k1 = c1_cnt;
      reset_n = 1'b0;
      @(negedge clock);
      check("rm_no_ack", c1_cnt - k1, 0);
      check("rm_mem", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 0);
      check("rm_c_rdata", 32'(c_rdata), 0);
      check("rm_ext_rdata", 32'(ext_rdata), 0);
      check("rm_state", 32'(dbg_state), 32'(IDLE));
      reset_n = 1'b1;
      c2_we = 1'b0; c2_addr = 9'd2; c2_req = 1'b1; c2_owed = 1'b1;
      exp_q.push_back(ref_mem[1]);
      k2 = c2_cnt;
      wait_ack(1, n, got);
      c1_owed = 1'b0; c1_req = 1'b0;
      check("rm_c1_first", 32'(got), 1);
      check("rm_c1_lat", n, 3);
      check("rm_c2_not_first", c2_cnt - k2, 0);
      check("rm_c1_data", 32'(c_rdata), 32'(exp_q.pop_front()));
      exp_q.push_back(ref_mem[2]);
      wait_ack(2, n, got);
      c2_owed = 1'b0; c2_req = 1'b0;
      check("rm_c2_next", 32'(got), 1);
      check("rm_c2_data", 32'(c_rdata), 32'(exp_q.pop_front()));

      repeat (3) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
